exp_pulse_synth: RTL and testbench

- Synthesizes detector-like ADC sample streams for the trapezoidal shaping chain: a short linear rise followed by an exponential decay on a programmable baseline.
- Output format matches the ADC sample stream the shapers consume: signed, SIZE_ADC_DATA wide, one sample per clk.
- Used as on-chip test-pulse source and as stimulus for shaper calibration, since its decay constant maps to the shaper's M.
- Supports external triggers, periodic auto-triggering and pile-up.

---
 rtl/exp_pulse_synth_pkg.sv | 20 ++
 rtl/package_settings.sv | 4 +
 rtl/sat_add.sv | 35 +++
 rtl/exp_pulse_synth.sv | 128 ++++++++++++
 tb/tb_exp_pulse_synth.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/exp_pulse_synth_pkg.sv
// Constants and types for the exponential test-pulse synthesizer.
package exp_pulse_synth_params;
  import package_settings::*;

  localparam int DECAY_SHIFT = 6;
  localparam int RISE_LOG2   = 2;
  localparam int FRAC        = 8;
  localparam int PERIOD      = 1000;

  localparam int ACC_W    = SIZE_ADC_DATA + FRAC + 2;
  localparam int RISE_LEN = 1 << RISE_LOG2;
  localparam int RISE_CW  = (RISE_LOG2 > 0) ? RISE_LOG2 : 1;
  localparam int PERIOD_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } state_t;
endpackage

// File: rtl/package_settings.sv
// Project-wide data-path settings shared by the ADC front end and the shaping chain.
package package_settings;
  localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/sat_add.sv
// Signed adder whose result is clamped to the OUT_W-bit two's-complement range.
module sat_add
  import package_settings::*;
#(
  parameter int A_W   = SIZE_ADC_DATA,
  parameter int B_W   = SIZE_ADC_DATA,
  parameter int OUT_W = SIZE_ADC_DATA
) (
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [OUT_W-1:0] sum
);
  localparam int S_W = ((A_W > B_W) ? A_W : B_W) + 1;
  localparam logic signed [S_W-1:0] MAX_V = {{(S_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] MIN_V = {{(S_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [S_W-1:0] a_ext_s;
  logic signed [S_W-1:0] b_ext_s;
  logic signed [S_W-1:0] sum_s;

  assign a_ext_s = a;
  assign b_ext_s = b;
  assign sum_s   = a_ext_s + b_ext_s;

  // Clamp the full-precision sum into the output range.
  always_comb begin
    if (sum_s > MAX_V) begin
      sum = MAX_V[OUT_W-1:0];
    end else if (sum_s < MIN_V) begin
      sum = MIN_V[OUT_W-1:0];
    end else begin
      sum = sum_s[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/exp_pulse_synth.sv
// Detector-like pulse source: linear rise, exponential decay, on a programmable baseline.
// Supports external and periodic triggers and pile-up onto the residual tail.
module exp_pulse_synth
  import package_settings::*;
  import exp_pulse_synth_params::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            auto_mode,
  input  logic                            trigger,
  input  logic        [SIZE_ADC_DATA-1:0] amplitude,
  input  logic signed [SIZE_ADC_DATA-1:0] baseline,
  output logic signed [SIZE_ADC_DATA-1:0] output_data,
  output logic                            busy,
  output logic                            pulse_start,
  output logic                            trig_dropped
);
  state_t                           state_r, state_s;
  logic signed [ACC_W-1:0]          acc_r, acc_next_s, inj_s, amp_ext_s;
  logic        [SIZE_ADC_DATA-1:0]  amp_lat_r, amp_lat_s;
  logic        [RISE_CW-1:0]        rise_cnt_r, rise_cnt_s;
  logic        [PERIOD_W-1:0]       period_cnt_r, period_cnt_s;
  logic signed [ACC_W-FRAC-1:0]     acc_int_s;
  logic signed [SIZE_ADC_DATA-1:0]  sample_s;
  logic                             trig_eff_s, tail_zero_s;
  logic                             pulse_start_s, trig_dropped_s;

  assign trig_eff_s  = trigger | (auto_mode & (period_cnt_r == PERIOD_W'(PERIOD - 1)));
  assign amp_ext_s   = {{(ACC_W-SIZE_ADC_DATA){1'b0}}, amp_lat_r};
  assign inj_s       = (state_r == RISE) ? ((amp_ext_s <<< FRAC) >>> RISE_LOG2) : {ACC_W{1'b0}};
  assign acc_next_s  = acc_r - (acc_r >>> DECAY_SHIFT) + inj_s;
  assign acc_int_s   = acc_next_s[ACC_W-1:FRAC];
  assign tail_zero_s = (acc_r[ACC_W-1:FRAC] == {(ACC_W-FRAC){1'b0}});
  assign busy        = (state_r == RISE) || (state_r == DECAY);

  sat_add #(
    .A_W  (SIZE_ADC_DATA),
    .B_W  (ACC_W - FRAC),
    .OUT_W(SIZE_ADC_DATA)
  ) u_sat_add (
    .a  (baseline),
    .b  (acc_int_s),
    .sum(sample_s)
  );

  // Free-running auto-trigger period counter, parked at zero outside auto mode.
  always_comb begin
    if (!auto_mode) begin
      period_cnt_s = {PERIOD_W{1'b0}};
    end else if (period_cnt_r == PERIOD_W'(PERIOD - 1)) begin
      period_cnt_s = {PERIOD_W{1'b0}};
    end else begin
      period_cnt_s = period_cnt_r + PERIOD_W'(1);
    end
  end

  // Pulse sequencing: accept, rise, decay, and pile-up re-trigger from DECAY.
  always_comb begin
    state_s        = state_r;
    amp_lat_s      = amp_lat_r;
    rise_cnt_s     = rise_cnt_r;
    pulse_start_s  = 1'b0;
    trig_dropped_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig_eff_s) begin
          amp_lat_s     = amplitude;
          rise_cnt_s    = {RISE_CW{1'b0}};
          pulse_start_s = 1'b1;
          state_s       = RISE;
        end else begin
          state_s = IDLE;
        end
      end
      RISE: begin
        rise_cnt_s     = rise_cnt_r + RISE_CW'(1);
        trig_dropped_s = trig_eff_s;
        if (rise_cnt_r == RISE_CW'(RISE_LEN - 1)) begin
          state_s = DECAY;
        end else begin
          state_s = RISE;
        end
      end
      DECAY: begin
        if (trig_eff_s) begin
          amp_lat_s     = amplitude;
          rise_cnt_s    = {RISE_CW{1'b0}};
          pulse_start_s = 1'b1;
          state_s       = RISE;
        end else if (tail_zero_s) begin
          state_s = IDLE;
        end else begin
          state_s = DECAY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, accumulator and registered outputs; everything freezes while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      acc_r        <= {ACC_W{1'b0}};
      amp_lat_r    <= {SIZE_ADC_DATA{1'b0}};
      rise_cnt_r   <= {RISE_CW{1'b0}};
      period_cnt_r <= {PERIOD_W{1'b0}};
      output_data  <= {SIZE_ADC_DATA{1'b0}};
      pulse_start  <= 1'b0;
      trig_dropped <= 1'b0;
    end else if (enable) begin
      state_r      <= state_s;
      acc_r        <= acc_next_s;
      amp_lat_r    <= amp_lat_s;
      rise_cnt_r   <= rise_cnt_s;
      period_cnt_r <= period_cnt_s;
      output_data  <= sample_s;
      pulse_start  <= pulse_start_s;
      trig_dropped <= trig_dropped_s;
    end else begin
      pulse_start  <= 1'b0;
      trig_dropped <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exp_pulse_synth.sv
// Self-checking bench for exp_pulse_synth: a per-cycle vector table plus directed sequences.
module tb_exp_pulse_synth;
  import package_settings::*;

  logic                            clk = 1'b0;
  logic                            reset = 1'b0;
  logic                            enable = 1'b0;
  logic                            auto_mode = 1'b0;
  logic                            trigger = 1'b0;
  logic        [SIZE_ADC_DATA-1:0] amplitude = '0;
  logic signed [SIZE_ADC_DATA-1:0] baseline = '0;
  logic signed [SIZE_ADC_DATA-1:0] output_data;
  logic                            busy, pulse_start, trig_dropped;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic en; logic am; logic tr; int amp; int base;
    int out; logic bsy; logic ps; logic td;
  } vec_t;
  vec_t vecs[14];

  exp_pulse_synth dut (
    .clk(clk), .reset(reset), .enable(enable), .auto_mode(auto_mode),
    .trigger(trigger), .amplitude(amplitude), .baseline(baseline),
    .output_data(output_data), .busy(busy), .pulse_start(pulse_start),
    .trig_dropped(trig_dropped)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=[%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; trigger = 1'b0; auto_mode = 1'b0; enable = 1'b1;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic wait_ps(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (!pulse_start && n < limit);
  endtask

  initial begin
    int n, p1, p2, hold, mx, mn;
    real r;

    // amplitude 1000 -> 64000 injected per rise cycle; acc/256 hand-computed per cycle
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1000,     0,     0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1000,     0,   250, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1000,     0,   496, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0,    7,     0,   738, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1000,     0,   976, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1000,     0,   961, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1000,   100,  1046, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1000,     0,   931, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1000,  2000,  2047, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1000, -2048, -1146, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1000,     0, -1146, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1000,     0,   888, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1,  500,     0,   874, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0,  500,     0,   986, 1'b1, 1'b0, 1'b0};

    // Reset values, including asynchronous assertion without a clock edge
    do_reset();
    reset = 1'b0;
    #2;
    check("rst_out", int'(output_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ps", int'(pulse_start), 0);
    check("rst_td", int'(trig_dropped), 0);
    reset = 1'b1;

    // Quiet baseline
    baseline = 12'sd100;
    for (int i = 0; i < 50; i++) begin
      step();
      check("baseline_out", int'(output_data), 100);
      check("baseline_busy", int'(busy), 0);
    end

    // Cycle-by-cycle vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      enable = vecs[i].en; auto_mode = vecs[i].am; trigger = vecs[i].tr;
      amplitude = 12'(vecs[i].amp); baseline = 12'(vecs[i].base);
      step();
      check($sformatf("vec%0d_out", i), int'(output_data), vecs[i].out);
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
      check($sformatf("vec%0d_ps", i), int'(pulse_start), int'(vecs[i].ps));
      check($sformatf("vec%0d_td", i), int'(trig_dropped), int'(vecs[i].td));
    end
    trigger = 1'b0;

    // Single pulse: peak, one-tau decay, return to idle
    do_reset();
    baseline = 12'sd0; amplitude = 12'd1000; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("single_ps", int'(pulse_start), 1);
    repeat (4) step();
    p1 = int'(output_data);
    check_range("single_peak", p1, 955, 1000);
    repeat (64) step();
    r = 976.0;
    for (int i = 0; i < 64; i++) r = r * 63.0 / 64.0;
    check_range("single_tau", int'(output_data), int'(r * 0.98), int'(r * 1.02) + 1);
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    check("single_idle_busy", int'(busy), 0);
    check("single_idle_out", int'(output_data), 0);

    // Pile-up: second trigger 20 cycles after the first lands on the tail
    do_reset();
    amplitude = 12'd1000; trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (4) step();
    p1 = int'(output_data);
    check("pile_peak1", p1, 976);
    repeat (15) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("pile_ps", int'(pulse_start), 1);
    repeat (4) step();
    p2 = int'(output_data);
    r = 976.8;
    for (int i = 0; i < 20; i++) r = r * 63.0 / 64.0;
    r = r + 976.8;
    check_range("pile_peak2", p2, int'(r) - 10, int'(r) + 10);

    // Saturation high: never wraps negative, clamps at the top code
    do_reset();
    baseline = 12'sd2000; amplitude = 12'd2000; trigger = 1'b1;
    mx = -5000; mn = 5000;
    for (int i = 0; i < 100; i++) begin
      step();
      trigger = 1'b0;
      if (int'(output_data) > mx) mx = int'(output_data);
      if (int'(output_data) < mn) mn = int'(output_data);
    end
    check("sat_max", mx, 2047);
    check_range("sat_min", mn, 2000, 2047);

    // Saturation low with a zero-amplitude pulse
    do_reset();
    baseline = -12'sd2048; amplitude = 12'd0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("amp0_ps", int'(pulse_start), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("amp0_out", int'(output_data), -2048);
      check("amp0_busy", int'(busy), 1);
    end

    // Auto mode period, enable gap and mid-period toggle
    do_reset();
    baseline = 12'sd0; amplitude = 12'd300; auto_mode = 1'b1;
    wait_ps(n, 1200);
    check("auto_first", n, 1000);
    for (int i = 0; i < 4; i++) begin
      wait_ps(n, 1200);
      check("auto_period", n, 1000);
    end
    repeat (20) step();
    hold = int'(output_data);
    enable = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step();
      check("gap_hold", int'(output_data), hold);
      check("gap_ps", int'(pulse_start), 0);
    end
    enable = 1'b1;
    wait_ps(n, 1200);
    check("gap_period", 57 + n, 1037);
    repeat (300) step();
    auto_mode = 1'b0;
    step();
    auto_mode = 1'b1;
    wait_ps(n, 1200);
    check("toggle_period", n, 1000);
    auto_mode = 1'b0;

    // Reset mid-decay: asynchronous clear and no tail afterwards
    do_reset();
    amplitude = 12'd1000; trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (10) step();
    check_range("mid_decay_out", int'(output_data), 500, 1000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_out", int'(output_data), 0);
    check("async_rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst_out", int'(output_data), 0);
    end
    check("post_rst_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
